// File: rtl/bound_flash_gen_if.sv
// bound_flash_gen_if
//   Groups the lamp sequencer's control inputs and display/status outputs.
//   Ports carried:
//     flick  - start / kickback request (driven by master)
//     hold   - freeze request            (driven by master)
//     lamps  - N_LAMP-bit thermometer lamp bar (driven by slave)
//     phase  - 3-bit current state code  (driven by slave)
//     done   - one-cycle end-of-sequence pulse (driven by slave)
interface bound_flash_gen_if #(
  parameter int N_LAMP = 16
);
  logic              flick;
  logic              hold;
  logic [N_LAMP-1:0] lamps;
  logic [2:0]        phase;
  logic              done;

  modport master (
    output flick,
    output hold,
    input  lamps,
    input  phase,
    input  done
  );

  modport slave (
    input  flick,
    input  hold,
    output lamps,
    output phase,
    output done
  );
endinterface

// File: rtl/bound_flash_gen.sv
// bound_flash_gen
//   Drives a thermometer-coded lamp bar through a fixed up/down bounce
//   pattern: 0 -> N_LAMP -> B1 -> B2 -> 0 -> B1 -> 0. Supports a kickback
//   on flick during the rises, a hold that freezes everything, a phase
//   status output and a one-cycle done pulse at the end of a sequence.
//   Ports:
//     clk   - system clock, rising edge
//     rst_n - asynchronous active-low reset
//     bus   - bound_flash_gen_if.slave (flick, hold in; lamps, phase, done out)
//
//   state | meaning
//   ------+-------------------------------------------------------
//   IDLE  | bar dark, waiting for flick on a tick
//   UP1   | rising 0 -> N_LAMP, kicks to KICK at B1/B2 on flick
//   DN1   | falling to B1
//   UP2   | rising to B2, flick at B2 re-enters DN1
//   DN2   | falling to 0
//   UP3   | rising to B1
//   DN3   | falling to 0, then done pulse and back to IDLE
//   KICK  | falling to 0, then restart UP1
module bound_flash_gen #(
  parameter int N_LAMP   = 16,
  parameter int B1       = 5,
  parameter int B2       = 10,
  parameter int TICK_DIV = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bound_flash_gen_if.slave     bus
);

  localparam int CW = $clog2(N_LAMP + 1);
  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [CW-1:0] TGT_TOP  = CW'(N_LAMP);
  localparam logic [CW-1:0] TGT_B1   = CW'(B1);
  localparam logic [CW-1:0] TGT_B2   = CW'(B2);
  localparam logic [CW-1:0] TGT_ZERO = '0;
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

  if (N_LAMP < 4) begin : g_chk_nlamp
    $fatal(1, "bound_flash_gen: N_LAMP must be at least 4");
  end
  if (!(B1 > 0 && B1 < B2)) begin : g_chk_b1
    $fatal(1, "bound_flash_gen: need 0 < B1 < B2");
  end
  if (B2 >= N_LAMP) begin : g_chk_b2
    $fatal(1, "bound_flash_gen: need B2 < N_LAMP");
  end
  if (TICK_DIV < 1) begin : g_chk_div
    $fatal(1, "bound_flash_gen: TICK_DIV must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    UP1  = 3'd1,
    DN1  = 3'd2,
    UP2  = 3'd3,
    DN2  = 3'd4,
    UP3  = 3'd5,
    DN3  = 3'd6,
    KICK = 3'd7
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   count_inc, count_dec;
  logic [DW-1:0]   div_q, div_d;
  logic            done_q, done_d;
  logic            tick;
  logic [N_LAMP-1:0] lamps_w;

  assign count_inc = count_q + CW'(1);
  assign count_dec = count_q - CW'(1);

  // Divider only runs while hold is low, so a hold resumes the step
  // cadence from exactly where it stopped.
  assign tick = (div_q == DIV_LAST) && !bus.hold;

  always_comb begin
    div_d = div_q;
    if (!bus.hold) begin
      if (div_q == DIV_LAST) div_d = '0;
      else                   div_d = div_q + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      div_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      div_q   <= div_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (bus.flick) state_d = UP1;
        end
        UP1: begin
          count_d = count_inc;
          // Kickback outranks the top-of-bar target.
          if (bus.flick && (count_inc == TGT_B1 || count_inc == TGT_B2))
            state_d = KICK;
          else if (count_inc == TGT_TOP)
            state_d = DN1;
        end
        DN1: begin
          count_d = count_dec;
          if (count_dec == TGT_B1) state_d = UP2;
        end
        UP2: begin
          count_d = count_inc;
          if (count_inc == TGT_B2) state_d = bus.flick ? DN1 : DN2;
        end
        DN2: begin
          count_d = count_dec;
          if (count_dec == TGT_ZERO) state_d = UP3;
        end
        UP3: begin
          count_d = count_inc;
          if (count_inc == TGT_B1) state_d = DN3;
        end
        DN3: begin
          count_d = count_dec;
          if (count_dec == TGT_ZERO) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        KICK: begin
          count_d = count_dec;
          if (count_dec == TGT_ZERO) state_d = UP1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    lamps_w = '0;
    for (int i = 0; i < N_LAMP; i++) lamps_w[i] = (i < int'(count_q));
  end

  assign bus.lamps = lamps_w;
  assign bus.phase = state_q;
  // Masked by hold so a freeze that starts right after the last step
  // never shows a done pulse.
  assign bus.done  = done_q && !bus.hold;

endmodule

// File: tb/tb_bound_flash_gen.sv
module tb_bound_flash_gen;
  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  bound_flash_gen_if #(.N_LAMP(16)) if_a ();
  bound_flash_gen_if #(.N_LAMP(16)) if_b ();

  bound_flash_gen #(.N_LAMP(16), .B1(5), .B2(10), .TICK_DIV(1)) dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if_a.slave)
  );

  bound_flash_gen #(.N_LAMP(16), .B1(5), .B2(10), .TICK_DIV(4)) dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] therm(input int c);
    logic [31:0] v;
    v = (32'd1 << c) - 32'd1;
    return v[15:0];
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  // Launch a sequence on dut_a: one-tick flick pulse, ends right after tick 0.
  task automatic start_a();
    if_a.flick = 1'b1;
    step(1);
    if_a.flick = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if_a.flick = 1'b0; if_a.hold = 1'b0;
    if_b.flick = 1'b0; if_b.hold = 1'b0;
    step(3);
    checks++;
    if ({if_a.lamps, if_a.phase, if_a.done} !== 20'h0 ||
        {if_b.lamps, if_b.phase, if_b.done} !== 20'h0) begin
      errors++;
      $display("FAIL reset_in: a=%h/%0d/%b b=%h/%0d/%b required all 0",
               if_a.lamps, if_a.phase, if_a.done, if_b.lamps, if_b.phase, if_b.done);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      checks++;
      if ({if_a.lamps, if_a.phase, if_a.done} !== 20'h0) begin
        errors++;
        $display("FAIL idle_cycle%0d: lamps=%h phase=%0d done=%b required 0/0/0",
                 i, if_a.lamps, if_a.phase, if_a.done);
      end
    end
  endtask

  task automatic test_full_sequence();
    int done_cnt;
    int exp_c;
    int exp_p;
    bit chk;
    apply_reset();
    start_a();
    checks++;
    if (if_a.phase !== 3'd1 || if_a.lamps !== 16'h0) begin
      errors++;
      $display("FAIL seq_start: phase=%0d lamps=%h required 1/0000", if_a.phase, if_a.lamps);
    end
    done_cnt = 0;
    for (int t = 1; t <= 53; t++) begin
      step(1);
      if (if_a.done === 1'b1) done_cnt++;
      chk = 1'b1;
      case (t)
        16: begin exp_c = 16; exp_p = 2; end
        27: begin exp_c = 5;  exp_p = 3; end
        32: begin exp_c = 10; exp_p = 4; end
        42: begin exp_c = 0;  exp_p = 5; end
        47: begin exp_c = 5;  exp_p = 6; end
        52: begin exp_c = 0;  exp_p = 0; end
        8:  begin exp_c = 8;  exp_p = 1; end
        default: begin exp_c = 0; exp_p = 0; chk = 1'b0; end
      endcase
      if (chk) begin
        checks++;
        if (if_a.lamps !== therm(exp_c) || if_a.phase !== 3'(exp_p)) begin
          errors++;
          $display("FAIL seq_tick%0d: lamps=%h phase=%0d required %h/%0d",
                   t, if_a.lamps, if_a.phase, therm(exp_c), exp_p);
        end
      end
      if (t == 51 || t == 52 || t == 53) begin
        checks++;
        if (if_a.done !== (t == 52)) begin
          errors++;
          $display("FAIL seq_done_t%0d: done=%b required %b", t, if_a.done, (t == 52));
        end
      end
    end
    checks++;
    if (done_cnt != 1 || if_a.phase !== 3'd0) begin
      errors++;
      $display("FAIL seq_done_count: pulses=%0d phase=%0d required 1/0", done_cnt, if_a.phase);
    end
  endtask

  task automatic test_up1_kick();
    apply_reset();
    start_a();
    step(4);
    if_a.flick = 1'b1;
    step(1);
    if_a.flick = 1'b0;
    checks++;
    if (if_a.phase !== 3'd7 || if_a.lamps !== therm(5)) begin
      errors++;
      $display("FAIL up1_kick_enter: phase=%0d lamps=%h required 7/%h", if_a.phase, if_a.lamps, therm(5));
    end
    for (int c = 4; c >= 1; c--) begin
      step(1);
      checks++;
      if (if_a.phase !== 3'd7 || if_a.lamps !== therm(c)) begin
        errors++;
        $display("FAIL up1_kick_down%0d: phase=%0d lamps=%h required 7/%h", c, if_a.phase, if_a.lamps, therm(c));
      end
    end
    step(1);
    checks++;
    if (if_a.phase !== 3'd1 || if_a.lamps !== 16'h0) begin
      errors++;
      $display("FAIL up1_kick_exit: phase=%0d lamps=%h required 1/0000", if_a.phase, if_a.lamps);
    end
    step(1);
    checks++;
    if (if_a.phase !== 3'd1 || if_a.lamps !== therm(1)) begin
      errors++;
      $display("FAIL up1_kick_rise: phase=%0d lamps=%h required 1/%h", if_a.phase, if_a.lamps, therm(1));
    end
  endtask

  task automatic test_up2_kick();
    int t;
    apply_reset();
    start_a();
    step(31);
    checks++;
    if (if_a.phase !== 3'd3 || if_a.lamps !== therm(9)) begin
      errors++;
      $display("FAIL up2_pre: phase=%0d lamps=%h required 3/%h", if_a.phase, if_a.lamps, therm(9));
    end
    if_a.flick = 1'b1;
    step(1);
    if_a.flick = 1'b0;
    checks++;
    if (if_a.phase !== 3'd2 || if_a.lamps !== therm(10)) begin
      errors++;
      $display("FAIL up2_kick: phase=%0d lamps=%h required 2/%h", if_a.phase, if_a.lamps, therm(10));
    end
    step(5);
    checks++;
    if (if_a.phase !== 3'd3 || if_a.lamps !== therm(5)) begin
      errors++;
      $display("FAIL up2_redescend: phase=%0d lamps=%h required 3/%h", if_a.phase, if_a.lamps, therm(5));
    end
    step(5);
    checks++;
    if (if_a.phase !== 3'd4 || if_a.lamps !== therm(10)) begin
      errors++;
      $display("FAIL up2_repeat: phase=%0d lamps=%h required 4/%h", if_a.phase, if_a.lamps, therm(10));
    end
    t = 42;
    while (if_a.done !== 1'b1 && t < 120) begin
      step(1);
      t++;
    end
    checks++;
    if (if_a.done !== 1'b1 || t != 62) begin
      errors++;
      $display("FAIL up2_done: done=%b at tick %0d required 1 at tick 62", if_a.done, t);
    end
  endtask

  task automatic test_hold_divider();
    apply_reset();
    if_b.flick = 1'b1;
    step(3);
    checks++;
    if (if_b.phase !== 3'd0) begin
      errors++;
      $display("FAIL div_no_early_start: phase=%0d required 0", if_b.phase);
    end
    step(1);
    if_b.flick = 1'b0;
    checks++;
    if (if_b.phase !== 3'd1) begin
      errors++;
      $display("FAIL div_start: phase=%0d required 1", if_b.phase);
    end
    step(3);
    checks++;
    if (if_b.lamps !== 16'h0) begin
      errors++;
      $display("FAIL div_between: lamps=%h required 0000", if_b.lamps);
    end
    step(1);
    checks++;
    if (if_b.lamps !== therm(1)) begin
      errors++;
      $display("FAIL div_step1: lamps=%h required %h", if_b.lamps, therm(1));
    end
    step(4 * 17);
    checks++;
    if (if_b.phase !== 3'd2 || if_b.lamps !== therm(14)) begin
      errors++;
      $display("FAIL div_dn1: phase=%0d lamps=%h required 2/%h", if_b.phase, if_b.lamps, therm(14));
    end
    step(2);
    if_b.hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      checks++;
      if (if_b.phase !== 3'd2 || if_b.lamps !== therm(14) || if_b.done !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d: phase=%0d lamps=%h done=%b required 2/%h/0",
                 i, if_b.phase, if_b.lamps, if_b.done, therm(14));
      end
    end
    if_b.hold = 1'b0;
    step(1);
    checks++;
    if (if_b.lamps !== therm(14)) begin
      errors++;
      $display("FAIL hold_resume_wait: lamps=%h required %h", if_b.lamps, therm(14));
    end
    step(1);
    checks++;
    if (if_b.lamps !== therm(13) || if_b.phase !== 3'd2) begin
      errors++;
      $display("FAIL hold_resume_step: lamps=%h phase=%0d required %h/2", if_b.lamps, if_b.phase, therm(13));
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    start_a();
    step(30);
    checks++;
    if (if_a.phase !== 3'd3 || if_a.lamps !== therm(8)) begin
      errors++;
      $display("FAIL areset_pre: phase=%0d lamps=%h required 3/%h", if_a.phase, if_a.lamps, therm(8));
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (if_a.lamps !== 16'h0 || if_a.phase !== 3'd0 || if_a.done !== 1'b0) begin
      errors++;
      $display("FAIL areset_immediate: lamps=%h phase=%0d done=%b required 0/0/0",
               if_a.lamps, if_a.phase, if_a.done);
    end
    step(2);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      checks++;
      if (if_a.done !== 1'b0 || if_a.phase !== 3'd0 || if_a.lamps !== 16'h0) begin
        errors++;
        $display("FAIL areset_after%0d: done=%b phase=%0d lamps=%h required 0/0/0",
                 i, if_a.done, if_a.phase, if_a.lamps);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_sequence();
    test_up1_kick();
    test_up2_kick();
    test_hold_divider();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bound_flash_gen.md
Name: bound_flash_gen

Overview:
- Parametrised successor of the team's 16-lamp bound-flash sequencer.
- Drives an N_LAMP thermometer-coded lamp bar through a fixed up/down bounce pattern.
- Generalised in lamp count, bounce points and step rate; adds hold, flick kickback in two phases, phase status and an end-of-sequence pulse.
- Sits between the board clock/reset and the LED outputs.

Parameters:
- N_LAMP, 16: number of lamps. Minimum 4.
- B1, 5: first bounce point, in lamps lit. Constraint: 0 < B1 < B2.
- B2, 10: second bounce point, in lamps lit. Constraint: B2 < N_LAMP.
- TICK_DIV, 1: clock cycles per lamp step. Minimum 1.

Ports:
- clk, input, 1: single system clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- flick, input, 1: start and kickback request. Sampled only on step ticks.
- hold, input, 1: freezes the tick divider, count and state while 1.
- lamps, output, N_LAMP: thermometer code. Bit i is 1 iff i < count.
- phase, output, 3: current state encoding.
- done, output, 1: one-cycle pulse when a full sequence ends.

Behaviour:
- Reset (async, rst_n=0): count=0, state=IDLE, divider=0, lamps=0, phase=0, done=0. Reset mid-sequence aborts immediately, with no completion of the current step.
- Tick: asserted when divider==TICK_DIV-1 and hold=0. The divider wraps to 0 on a tick and does not advance while hold=1. TICK_DIV=1 gives a tick every cycle while hold=0.
- Count width: clog2(N_LAMP+1). lamps is decoded directly from the count register (zero added latency). The count never leaves the range 0..N_LAMP.
- States and phase codes: IDLE=0, UP1=1, DN1=2, UP2=3, DN2=4, UP3=5, DN3=6, KICK=7.
- UP states: on each tick, count<=count+1. When count+1 equals the target, move to the next state on the same edge.
- DN states: on each tick, count<=count-1. When count-1 equals the target, move to the next state on the same edge.
- All transitions below occur only on ticks:
  - IDLE: if flick=1, go to UP1 with count unchanged (0). Otherwise stay in IDLE.
  - UP1 (target N_LAMP): go to DN1.
  - DN1 (target B1): go to UP2.
  - UP2 (target B2): go to DN2.
  - DN2 (target 0): go to UP3.
  - UP3 (target B1): go to DN3.
  - DN3 (target 0): go to IDLE and register done=1 for exactly the next cycle.
  - KICK (target 0): go to UP1.
- Kickback in UP1: on a tick where count+1 is B1 or B2 and flick=1, the increment still happens and the state goes to KICK. Kickback takes priority over the normal UP1 target check.
- Kickback in UP2: on a tick where count+1==B2 and flick=1, the state goes to DN1 instead of DN2. This re-descends to B1 and repeats UP2.
- No kickback applies in any other state. flick between ticks is ignored.
- With flick held at 1 continuously, UP1 kicks at B1 indefinitely. This is legal and required behaviour.
- hold=1: count, state and divider are frozen and lamps are stable. done is never asserted while hold=1.
- Nominal sequence with no kicks: 52 ticks from leaving IDLE to re-entering IDLE (16+11+5+10+5+5 with defaults).
- The parameter constraints are checked at elaboration; a violation is a fatal error.

Test Plan:
- Reset/idle: rst_n=0 for 3 cycles, then 1, with flick=0 → lamps=0, phase=0, done=0 for 20 cycles.
- Full sequence (defaults): pulse flick for 1 cycle, then flick=0.
  - Count checkpoints: 16 at tick 16, 5 at tick 27, 10 at tick 32, 0 at tick 42, 5 at tick 47, 0 at tick 52.
  - done is high for exactly 1 cycle after tick 52, then phase=0.
- UP1 kickback: start the sequence, assert flick on the tick where lamps go 4→5.
  - phase=7 and lamps descend 5→0 over 5 ticks.
  - phase=1 follows, and lamps rise from 0 again.
- UP2 kickback: assert flick on the UP2 tick where lamps go 9→10.
  - phase=2, lamps fall back to 5, then UP2 repeats.
  - With flick=0 afterwards, the sequence completes with done=1.
- Hold and divider (TICK_DIV=4): confirm one step per 4 cycles. Assert hold for 10 cycles mid-DN1 → lamps and phase unchanged for the whole hold window; the step cadence resumes from the frozen divider value.
- Async reset mid-UP2: drop rst_n between clock edges → lamps=0 and phase=0 without waiting for a clock edge; no done pulse.
